// File: rtl/uart_config_sequencer.sv
// Master-side UART configuration sequencer: sends four config packets through the TX FIFO, awaiting an ack for each.
// Optional UART_CFG_SANITIZE_EN replaces reserved parity/stop options with 2'b00 and flags cfg_error_o.
module uart_config_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter logic [7:0]  ACKN_PKT       = 8'hA5,
    parameter logic [3:0]  DATA_WIDTH_ID  = 4'h1,
    parameter logic [3:0]  PARITY_MODE_ID = 4'h2,
    parameter logic [3:0]  STOP_BITS_ID   = 4'h3,
    parameter logic [3:0]  END_CONFIG_ID  = 4'hF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [1:0] cfg_data_width_i,
    input  logic [1:0] cfg_parity_mode_i,
    input  logic [1:0] cfg_stop_bits_i,
    input  logic       tx_fifo_full_i,
    output logic       tx_fifo_write_o,
    output logic [7:0] tx_data_o,
    input  logic       rx_fifo_empty_i,
    input  logic [7:0] rx_data_i,
    output logic       rx_fifo_read_o,
    output logic       busy_o,
    output logic       data_stream_mode_o,
    output logic       done_o,
    output logic       fail_o,
    output logic [1:0] retry_cnt_o,
    output logic       cfg_error_o
);

    localparam int unsigned        TIMER_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]         RETRY_LIMIT = 2'(MAX_RETRY);
    localparam logic [1:0]         LAST_IDX    = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        DONE,
        FAIL
    } state_t;

    state_t             state;
    logic [1:0]         idx;
    logic [1:0]         retry;
    logic [TIMER_W-1:0] timer;

    logic [1:0] opt_width;
    logic [1:0] opt_parity;
    logic [1:0] opt_stop;

    logic [1:0] parity_clean;
    logic [1:0] stop_clean;
    logic       illegal_opt;

`ifdef UART_CFG_SANITIZE_EN
    always_comb begin
        parity_clean = cfg_parity_mode_i;
        stop_clean   = cfg_stop_bits_i;
        illegal_opt  = 1'b0;
        if (cfg_parity_mode_i == 2'b11) begin
            parity_clean = 2'b00;
            illegal_opt  = 1'b1;
        end
        if (cfg_stop_bits_i == 2'b11) begin
            stop_clean  = 2'b00;
            illegal_opt = 1'b1;
        end
    end
`else
    always_comb begin
        parity_clean = cfg_parity_mode_i;
        stop_clean   = cfg_stop_bits_i;
        illegal_opt  = 1'b0;
    end
`endif

    function automatic logic [7:0] packet_byte(input logic [1:0] sel, input logic [1:0] width,
                                               input logic [1:0] parity, input logic [1:0] stop);
        case (sel)
            2'd0:    return {DATA_WIDTH_ID, 2'b00, width};
            2'd1:    return {PARITY_MODE_ID, 2'b00, parity};
            2'd2:    return {STOP_BITS_ID, 2'b00, stop};
            default: return {END_CONFIG_ID, 4'b0000};
        endcase
    endfunction

    // Options are pure data: captured on the accepted start, never reset.
    always_ff @(posedge clk_i) begin
        if (state == IDLE && start_i) begin
            opt_width  <= cfg_data_width_i;
            opt_parity <= parity_clean;
            opt_stop   <= stop_clean;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= IDLE;
            idx             <= 2'd0;
            retry           <= 2'd0;
            timer           <= '0;
            tx_fifo_write_o <= 1'b0;
            tx_data_o       <= 8'h00;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            fail_o          <= 1'b0;
            cfg_error_o     <= 1'b0;
        end else begin
            tx_fifo_write_o <= 1'b0;
            done_o          <= 1'b0;
            fail_o          <= 1'b0;
            cfg_error_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state       <= SEND;
                        idx         <= 2'd0;
                        retry       <= 2'd0;
                        busy_o      <= 1'b1;
                        cfg_error_o <= illegal_opt;
                    end
                end
                SEND: begin
                    if (!tx_fifo_full_i) begin
                        tx_fifo_write_o <= 1'b1;
                        tx_data_o       <= packet_byte(idx, opt_width, opt_parity, opt_stop);
                        timer           <= '0;
                        state           <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // A byte present in the timeout cycle wins over the timeout.
                    if (!rx_fifo_empty_i) begin
                        if (rx_data_i == ACKN_PKT) begin
                            if (idx == LAST_IDX) begin
                                state  <= DONE;
                                done_o <= 1'b1;
                            end else begin
                                idx   <= idx + 2'd1;
                                retry <= 2'd0;
                                state <= SEND;
                            end
                        end else begin
                            state  <= FAIL;
                            fail_o <= 1'b1;
                        end
                    end else if (timer == TIMER_LAST) begin
                        if (retry == RETRY_LIMIT) begin
                            state  <= FAIL;
                            fail_o <= 1'b1;
                        end else begin
                            retry <= retry + 2'd1;
                            state <= SEND;
                        end
                    end else if (!tx_fifo_write_o) begin
                        // The strobe cycle is not counted: the wait starts once the byte sits in the FIFO.
                        timer <= timer + 1'b1;
                    end
                end
                DONE, FAIL: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_fifo_read_o     = (state == WAIT_ACK) && !rx_fifo_empty_i;
    assign data_stream_mode_o = busy_o;
    assign retry_cnt_o        = retry;

endmodule

// File: tb/tb_uart_config_sequencer.sv
// Directed bench for uart_config_sequencer: scoreboard of expected TX bytes plus a scripted RX FIFO model.
module tb_uart_config_sequencer;

    localparam int TO = 16;

`ifdef UART_CFG_SANITIZE_EN
    localparam logic [7:0] SAN_PAR_PKT = 8'h22;
    localparam logic [7:0] SAN_STOP_PKT = 8'h30;
    localparam logic       SAN_ERR = 1'b1;
`else
    localparam logic [7:0] SAN_PAR_PKT = 8'h22;
    localparam logic [7:0] SAN_STOP_PKT = 8'h33;
    localparam logic       SAN_ERR = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b1;
    logic       start_i = 1'b0;
    logic [1:0] cfg_data_width_i = 2'b00;
    logic [1:0] cfg_parity_mode_i = 2'b00;
    logic [1:0] cfg_stop_bits_i = 2'b00;
    logic       tx_fifo_full_i = 1'b0;
    logic       tx_fifo_write_o;
    logic [7:0] tx_data_o;
    logic       rx_fifo_empty_i = 1'b1;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_fifo_read_o;
    logic       busy_o;
    logic       data_stream_mode_o;
    logic       done_o;
    logic       fail_o;
    logic [1:0] retry_cnt_o;
    logic       cfg_error_o;

    uart_config_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRY(3)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .start_i(start_i),
        .cfg_data_width_i(cfg_data_width_i),
        .cfg_parity_mode_i(cfg_parity_mode_i),
        .cfg_stop_bits_i(cfg_stop_bits_i),
        .tx_fifo_full_i(tx_fifo_full_i),
        .tx_fifo_write_o(tx_fifo_write_o),
        .tx_data_o(tx_data_o),
        .rx_fifo_empty_i(rx_fifo_empty_i),
        .rx_data_i(rx_data_i),
        .rx_fifo_read_o(rx_fifo_read_o),
        .busy_o(busy_o),
        .data_stream_mode_o(data_stream_mode_o),
        .done_o(done_o),
        .fail_o(fail_o),
        .retry_cnt_o(retry_cnt_o),
        .cfg_error_o(cfg_error_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int wr_cyc[$];
    int wr_retry[$];
    int nwr, npop, ndone, nfail, done_cyc, fail_cyc, pop_cyc, start_cyc;
    int ack_delay, ack_skip, ack_limit, acks_given, bad_idx, ack_at;
    logic [7:0] ack_byte;
    bit pop_pending;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic new_scenario();
        exp_q.delete();
        wr_cyc.delete();
        wr_retry.delete();
        nwr = 0; npop = 0; ndone = 0; nfail = 0;
        done_cyc = -1; fail_cyc = -1; pop_cyc = -1;
        ack_delay = 3; ack_skip = 0; ack_limit = 100; acks_given = 0;
        bad_idx = -1; ack_at = -1; pop_pending = 1'b0;
    endtask

    // One clock: sample registered outputs, score writes, run the RX FIFO model.
    task automatic step();
        logic [7:0] e;
        @(posedge clk_i);
        #1;
        cyc++;
        if (pop_pending) begin
            rx_fifo_empty_i = 1'b1;
            rx_data_i = 8'h00;
            pop_pending = 1'b0;
        end
        if (tx_fifo_write_o) begin
            nwr++;
            wr_cyc.push_back(cyc);
            wr_retry.push_back(int'(retry_cnt_o));
            check("write_queued", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("tx_data", tx_data_o, e);
            end
            if (ack_skip > 0) ack_skip--;
            else if (acks_given < ack_limit) begin
                ack_at = cyc + ack_delay;
                ack_byte = (nwr - 1 == bad_idx) ? 8'h00 : 8'hA5;
                acks_given++;
            end
        end
        if (done_o) begin ndone++; done_cyc = cyc; end
        if (fail_o) begin nfail++; fail_cyc = cyc; end
        if (ack_at == cyc) begin
            rx_fifo_empty_i = 1'b0;
            rx_data_i = ack_byte;
            ack_at = -1;
        end
        #1;
        if (rx_fifo_read_o) begin
            pop_pending = 1'b1;
            npop++;
            pop_cyc = cyc;
        end
    endtask

    task automatic wait_end(input int budget);
        int n0;
        int k;
        n0 = ndone + nfail;
        k = 0;
        while (ndone + nfail == n0 && k < budget) begin
            step();
            k++;
        end
        check("end_reached", ndone + nfail != n0, 1);
    endtask

    task automatic start_seq(input logic [1:0] w, input logic [1:0] p, input logic [1:0] s);
        cfg_data_width_i = w;
        cfg_parity_mode_i = p;
        cfg_stop_bits_i = s;
        start_i = 1'b1;
        start_cyc = cyc;
        step();
        start_i = 1'b0;
        cfg_data_width_i = ~w;
        cfg_parity_mode_i = ~p;
        cfg_stop_bits_i = ~s;
    endtask

    function automatic logic [9:0] out_vec();
        return {tx_fifo_write_o, rx_fifo_read_o, busy_o, data_stream_mode_o, done_o, fail_o,
                retry_cnt_o, cfg_error_o, 1'b0};
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        new_scenario();
        #1 rst_n_i = 1'b0;
        #2;
        check("reset_outputs", out_vec(), 10'd0);
        check("reset_tx_data", tx_data_o, 8'h00);
        repeat (3) step();
        rst_n_i = 1'b1;
        repeat (2) step();
        check("idle_outputs", out_vec(), 10'd0);

        // Nominal sequence with option latching, start ignored mid-sequence and in DONE.
        new_scenario();
        exp_q.push_back(8'h13); exp_q.push_back(8'h21); exp_q.push_back(8'h30); exp_q.push_back(8'hF0);
        start_seq(2'b11, 2'b01, 2'b00);
        check("nom_busy_n1", busy_o, 1);
        check("nom_dsm_n1", data_stream_mode_o, 1);
        check("nom_no_write_n1", tx_fifo_write_o, 0);
        step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_end(200);
        check("nom_first_write", wr_cyc.size() > 0 ? wr_cyc[0] : -1, start_cyc + 2);
        check("nom_writes", nwr, 4);
        check("nom_ack_to_strobe", wr_cyc.size() > 1 ? wr_cyc[1] - wr_cyc[0] : -1, 5);
        check("nom_done_lat", done_cyc, pop_cyc + 1);
        check("nom_busy_in_done", busy_o, 1);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("nom_busy_after_done", busy_o, 0);
        check("nom_done_one_cycle", done_o, 0);
        repeat (5) step();
        check("nom_start_in_done_ignored", nwr, 4);
        check("nom_done_count", ndone, 1);
        check("nom_fail_count", nfail, 0);
        check("nom_queue_drained", exp_q.size(), 0);

        // Timeout retry: packet 0 unanswered twice.
        new_scenario();
        ack_skip = 2;
        repeat (3) exp_q.push_back(8'h13);
        exp_q.push_back(8'h21); exp_q.push_back(8'h30); exp_q.push_back(8'hF0);
        start_seq(2'b11, 2'b01, 2'b00);
        wait_end(400);
        check("to_writes", nwr, 6);
        check("to_gap1", wr_cyc.size() > 1 ? wr_cyc[1] - wr_cyc[0] : -1, TO + 2);
        check("to_gap2", wr_cyc.size() > 2 ? wr_cyc[2] - wr_cyc[1] : -1, TO + 2);
        check("to_retry1", wr_retry.size() > 1 ? wr_retry[1] : -1, 1);
        check("to_retry2", wr_retry.size() > 2 ? wr_retry[2] : -1, 2);
        check("to_retry_cleared", wr_retry.size() > 3 ? wr_retry[3] : -1, 0);
        check("to_done", ndone, 1);
        check("to_queue_drained", exp_q.size(), 0);
        repeat (2) step();

        // Retry exhaustion.
        new_scenario();
        ack_limit = 0;
        repeat (4) exp_q.push_back(8'h13);
        start_seq(2'b11, 2'b01, 2'b00);
        wait_end(400);
        check("ex_writes", nwr, 4);
        check("ex_fail", nfail, 1);
        check("ex_no_done", ndone, 0);
        check("ex_retry_last", wr_retry.size() > 3 ? wr_retry[3] : -1, 3);
        check("ex_fail_lat", fail_cyc, wr_cyc.size() > 3 ? wr_cyc[3] + TO + 1 : -1);
        step();
        check("ex_idle", {busy_o, fail_o}, 2'b00);
        repeat (3) step();

        // Bad acknowledge after packet 1.
        new_scenario();
        bad_idx = 1;
        exp_q.push_back(8'h13); exp_q.push_back(8'h21);
        start_seq(2'b11, 2'b01, 2'b00);
        wait_end(200);
        check("bad_fail", nfail, 1);
        check("bad_pops", npop, 2);
        check("bad_fail_lat", fail_cyc, pop_cyc + 1);
        check("bad_writes", nwr, 2);
        repeat (3) step();
        check("bad_rx_consumed", rx_fifo_empty_i, 1);

        // TX FIFO backpressure for 10 cycles in SEND.
        new_scenario();
        exp_q.push_back(8'h13); exp_q.push_back(8'h21); exp_q.push_back(8'h30); exp_q.push_back(8'hF0);
        tx_fifo_full_i = 1'b1;
        start_seq(2'b11, 2'b01, 2'b00);
        repeat (10) step();
        check("bp_no_write_full", nwr, 0);
        tx_fifo_full_i = 1'b0;
        k = cyc;
        wait_end(200);
        check("bp_write_after_clear", wr_cyc.size() > 0 ? wr_cyc[0] : -1, k + 1);
        check("bp_done", ndone, 1);
        repeat (2) step();

        // Reset during WAIT_ACK of packet 2.
        new_scenario();
        ack_limit = 2;
        exp_q.push_back(8'h13); exp_q.push_back(8'h21); exp_q.push_back(8'h30);
        start_seq(2'b11, 2'b01, 2'b00);
        k = 0;
        while (nwr < 3 && k < 100) begin step(); k++; end
        check("rst_reached_pkt2", nwr, 3);
        repeat (3) step();
        rx_fifo_empty_i = 1'b0;
        rx_data_i = 8'hA5;
        rst_n_i = 1'b0;
        #1;
        check("rst_outputs", out_vec(), 10'd0);
        check("rst_tx_data", tx_data_o, 8'h00);
        repeat (2) step();
        rst_n_i = 1'b1;
        rx_fifo_empty_i = 1'b1;
        repeat (40) step();
        check("rst_no_more_writes", nwr, 3);
        check("rst_no_more_pops", npop, 2);
        check("rst_no_end_pulse", ndone + nfail, 0);
        check("rst_idle", busy_o, 0);

        // Ack arriving exactly in the timeout cycle of every packet.
        new_scenario();
        ack_delay = TO;
        exp_q.push_back(8'h13); exp_q.push_back(8'h21); exp_q.push_back(8'h30); exp_q.push_back(8'hF0);
        start_seq(2'b11, 2'b01, 2'b00);
        wait_end(300);
        check("tc_writes", nwr, 4);
        check("tc_gap", wr_cyc.size() > 1 ? wr_cyc[1] - wr_cyc[0] : -1, TO + 2);
        check("tc_retry_pkt1", wr_retry.size() > 1 ? wr_retry[1] : -1, 0);
        check("tc_retry_pkt3", wr_retry.size() > 3 ? wr_retry[3] : -1, 0);
        check("tc_done", ndone, 1);
        check("tc_no_fail", nfail, 0);
        repeat (2) step();

        // Reserved stop-bits option.
        new_scenario();
        exp_q.push_back(8'h10); exp_q.push_back(SAN_PAR_PKT); exp_q.push_back(SAN_STOP_PKT); exp_q.push_back(8'hF0);
        start_seq(2'b00, 2'b10, 2'b11);
        check("san_cfg_error", cfg_error_o, SAN_ERR);
        step();
        check("san_cfg_error_pulse", cfg_error_o, 0);
        wait_end(200);
        check("san_done", ndone, 1);
        check("san_queue_drained", exp_q.size(), 0);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
